cache_read_arbiter: RTL
=======================

CACHE_READ_ARBITER -- requirements
Module: cache_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of load reservation stations sharing the cache read port (2..8).
REQ-002 SHALL have parameter WORD_SIZE, default 32: address and data width.
REQ-003 SHALL have parameter MISS_STALL, default 4: extra cycles on a cache miss (legal range 1..15).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset is asynchronous and active-low.
REQ-006 SHALL have port req, input, NUM_REQ: bit i is the read request from load RS i; the RS holds it until its rvalid bit pulses.
REQ-007 SHALL have port addr_bus, input, NUM_REQ*WORD_SIZE: slice i holds the address of RS i; valid while req[i]=1.
REQ-008 SHALL have port flush, input, NUM_REQ: bit i cancels any pending or in-flight request of RS i.
REQ-009 SHALL have port gnt, output, NUM_REQ: one-hot; bit i high for the single ISSUE cycle of the transaction granted to RS i.
REQ-010 SHALL have port rvalid, output, NUM_REQ: one-hot, one-cycle pulse; rdata is valid for RS i.
REQ-011 SHALL have port rdata, output, WORD_SIZE: read data.
REQ-012 SHALL have port c_ptr, output, WORD_SIZE: cache read address.
REQ-013 SHALL have port c_read_enable, output, 1: cache read strobe.
REQ-014 SHALL have port c_out, input, WORD_SIZE: cache data.
REQ-015 SHALL have port c_hit, input, 1: cache hit for the current c_ptr.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, ISSUE, STALL, RESP.
REQ-018 SHALL arbitrate round-robin: eligible = req & ~flush; search starts at last_gnt+1 mod NUM_REQ; winner becomes last_gnt.
REQ-019 IDLE: if any requester is eligible at an edge, SHALL latch its index and addr slice, set c_ptr=addr, set c_read_enable=1 and gnt=onehot(index), then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-020 ISSUE lasts exactly one cycle, and SHALL deassert gnt at the following edge.
REQ-021 At the ISSUE edge with c_hit=1, SHALL latch rdata=c_out, drop c_read_enable and go to RESP.
REQ-022 At the ISSUE edge with c_hit=0, SHALL load the stall counter with MISS_STALL-1, hold c_read_enable and c_ptr, and go to STALL.
REQ-023 STALL SHALL decrement the counter each edge; at the edge where the counter is 0, SHALL latch rdata=c_out, drop c_read_enable and go to RESP.
REQ-024 Latency from the grant edge to the rvalid cycle SHALL be 2 cycles on a hit and 2+MISS_STALL cycles on a miss.
REQ-025 RESP SHALL pulse rvalid[index] for exactly one cycle.
REQ-026 RESP SHALL arbitrate excluding the served index; if a winner exists, SHALL go directly to ISSUE (back-to-back), else to IDLE.
REQ-027 If flush[index] is high in any cycle of ISSUE, STALL or RESP for the in-flight transaction, the cache access SHALL complete but rvalid SHALL NOT pulse for that transaction.
REQ-028 A flushed requester SHALL NOT be granted in the cycle its flush bit is high.
REQ-029 c_ptr and rdata SHALL hold their last values when not updated.
REQ-030 The counter width SHALL be 4 bits.
REQ-031 With NUM_REQ requesters continuously asserting req, each SHALL be served once per NUM_REQ grants (no starvation).

Reset
REQ-032 While reset_n=0, SHALL set state=IDLE, gnt=0, rvalid=0, c_read_enable=0, c_ptr=0, rdata=0, busy=0, counter=0 and last_gnt=NUM_REQ-1.
REQ-033 Assertion of reset_n mid-transaction SHALL discard the transaction immediately, with no rvalid pulse after release.
REQ-034 After reset release, the first grant SHALL go to the lowest-index eligible requester.

Verification
REQ-035 SHALL cover a single hit: req[0] with addr 0x40, c_hit=1, c_out=0x1234 -> gnt[0] one cycle, c_ptr=0x40, rvalid[0] 2 cycles after grant edge, rdata=0x1234.
REQ-036 SHALL cover a miss: req[1] with c_hit=0, MISS_STALL=4 -> c_read_enable high for 5 cycles, rvalid[1] 6 cycles after grant edge, rdata=c_out at the final STALL edge.
REQ-037 SHALL cover fairness: req=4'b1111 held, each requester dropping on its own rvalid -> grant order 0,1,2,3 with RESP->ISSUE back-to-back and no IDLE cycle.
REQ-038 SHALL cover flush: flush[2] pulsed during STALL of RS 2's miss -> no rvalid[2] pulse, FSM returns to IDLE, and the next request is granted normally.
REQ-039 SHALL cover async reset: reset_n low mid-STALL -> c_read_enable=0 and busy=0 without a clock edge, no rvalid after release, and first grant to requester 0.

Source files
------------

// File: rtl/cache_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_read_arbiter
// Purpose  : round-robin sharing of one cache read port among load RSs
// Revision : 1.0
// ============================================================================
module cache_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_SIZE  = 32,
  parameter int MISS_STALL = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WORD_SIZE-1:0] addr_bus,
  input  logic [NUM_REQ-1:0]           flush,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [WORD_SIZE-1:0]         rdata,
  output logic [WORD_SIZE-1:0]         c_ptr,
  output logic                         c_read_enable,
  input  logic [WORD_SIZE-1:0]         c_out,
  input  logic                         c_hit,
  output logic                         busy
);

  localparam int                 c_idx_w      = $clog2(NUM_REQ);
  localparam logic [3:0]         c_stall_load = 4'(MISS_STALL - 1);
  localparam logic [c_idx_w-1:0] c_last_rst   = c_idx_w'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q,    state_d;
  logic [c_idx_w-1:0]   idx_q,      idx_d;
  logic [c_idx_w-1:0]   last_gnt_q, last_gnt_d;
  logic [3:0]           cnt_q,      cnt_d;
  logic [WORD_SIZE-1:0] c_ptr_q,    c_ptr_d;
  logic [WORD_SIZE-1:0] rdata_q,    rdata_d;
  logic                 rd_en_q,    rd_en_d;
  logic                 flushed_q,  flushed_d;

  logic [WORD_SIZE-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   idx_onehot;
  logic [NUM_REQ-1:0]   elig;
  logic                 pick_found;
  logic [c_idx_w-1:0]   pick_idx;
  logic                 launch;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = addr_bus[i*WORD_SIZE +: WORD_SIZE];
  end

  assign idx_onehot = NUM_REQ'(1) << idx_q;

  // The RS being answered in RESP still holds req this cycle; mask it out.
  assign elig = req & ~flush &
                ((state_q == RESP) ? ~idx_onehot : {NUM_REQ{1'b1}});

  always_comb begin : rr_search
    logic [c_idx_w-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = c_idx_w'((int'(last_gnt_q) + off) % NUM_REQ);
      if (!pick_found && elig[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign launch = pick_found && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    c_ptr_d    = c_ptr_q;
    rdata_d    = rdata_q;
    rd_en_d    = rd_en_q;
    flushed_d  = flushed_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ISSUE: begin
        if (flush[idx_q]) flushed_d = 1'b1;
        if (c_hit) begin
          rdata_d = c_out;
          rd_en_d = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = c_stall_load;
          state_d = STALL;
        end
      end
      STALL: begin
        if (flush[idx_q]) flushed_d = 1'b1;
        if (cnt_q == 4'd0) begin
          rdata_d = c_out;
          rd_en_d = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // IDLE and RESP share the grant path, giving back-to-back issue from RESP.
    if (launch) begin
      state_d    = ISSUE;
      idx_d      = pick_idx;
      last_gnt_d = pick_idx;
      c_ptr_d    = addr_arr[pick_idx];
      rd_en_d    = 1'b1;
      flushed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_gnt_q <= c_last_rst;
      cnt_q      <= 4'd0;
      c_ptr_q    <= '0;
      rdata_q    <= '0;
      rd_en_q    <= 1'b0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      c_ptr_q    <= c_ptr_d;
      rdata_q    <= rdata_d;
      rd_en_q    <= rd_en_d;
      flushed_q  <= flushed_d;
    end
  end

  assign gnt           = (state_q == ISSUE) ? idx_onehot : '0;
  // A flush arriving in the RESP cycle itself must still suppress the pulse.
  assign rvalid        = ((state_q == RESP) && !flushed_q && !flush[idx_q]) ?
                         idx_onehot : '0;
  assign busy          = (state_q != IDLE);
  assign c_read_enable = rd_en_q;
  assign c_ptr         = c_ptr_q;
  assign rdata         = rdata_q;

endmodule
`default_nettype wire
